// File: rtl/one_hot_counter.sv
// Phase sequencer: binary count plus registered one-hot decode, driven by an IDLE/RUN/DONE FSM.
// Define ONE_HOT_COUNTER_AUTORESTART_EN to free-run as a ring instead of stopping after one sweep.
module one_hot_counter #(
  parameter int COUNT_W   = 4,
  parameter int ONE_HOT_W = 8
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 go,
  output logic [COUNT_W-1:0]   count,
  output logic [ONE_HOT_W-1:0] one_hot1
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(ONE_HOT_W - 1);

  state_t state;

  function automatic logic [ONE_HOT_W-1:0] decode(input logic [COUNT_W-1:0] c);
    decode = ONE_HOT_W'(1) << c;
  endfunction

  // count and one_hot1 are always written together so the decode never lags the count
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state    <= IDLE;
      count    <= '0;
      one_hot1 <= decode('0);
    end else begin
      case (state)
        IDLE: begin
          count    <= '0;
          one_hot1 <= decode('0);
          if (go) state <= RUN;
        end
        RUN: begin
          if (go) begin
            if (count == LAST) begin
              count    <= '0;
              one_hot1 <= decode('0);
`ifdef ONE_HOT_COUNTER_AUTORESTART_EN
              state    <= RUN;
`else
              state    <= DONE;
`endif
            end else begin
              count    <= count + COUNT_W'(1);
              one_hot1 <= decode(count + COUNT_W'(1));
            end
          end
        end
        DONE: begin
          count    <= '0;
          one_hot1 <= decode('0);
          if (!go) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          count    <= '0;
          one_hot1 <= decode('0);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_one_hot_counter.sv
// Directed bench for one_hot_counter: reset hold, sweep, pause, mid-run reset, restart after DONE.
module tb_one_hot_counter;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       go = 1'b0;
  logic [3:0] count;
  logic [7:0] one_hot1;

  int tests = 0;
  int fails = 0;

  one_hot_counter #(.COUNT_W(4), .ONE_HOT_W(8)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .go       (go),
    .count    (count),
    .one_hot1 (one_hot1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Apply go, take one rising edge, then compare both outputs against the expected phase
  task automatic step(input string tag, input logic g, input int exp_count);
    logic [7:0] exp_oh;
    go = g;
    @(posedge clk);
    #1;
    exp_oh = 8'h01 << exp_count;
    check({tag, "_count"}, 32'(count), 32'(exp_count));
    check({tag, "_onehot"}, 32'(one_hot1), 32'(exp_oh));
  endtask

  initial begin
    // reset hold
    nreset = 1'b0;
    step("reset", 1'b0, 0);
    nreset = 1'b1;
    for (int i = 0; i < 10; i++) step("idle_hold", 1'b0, 0);

    // single sweep with go held high: IDLE->RUN edge keeps 0, then 1..7, then wrap
    step("sweep_start", 1'b1, 0);
    for (int i = 1; i <= 7; i++) step("sweep", 1'b1, i);
    step("sweep_wrap", 1'b1, 0);

`ifdef ONE_HOT_COUNTER_AUTORESTART_EN
    // ring keeps running: 1..7,0 twice
    for (int lap = 0; lap < 2; lap++) begin
      for (int i = 1; i <= 7; i++) step("ring", 1'b1, i);
      step("ring_wrap", 1'b1, 0);
    end
    step("ring_a", 1'b1, 1);
    step("ring_b", 1'b1, 2);
    for (int i = 0; i < 3; i++) step("ring_pause", 1'b0, 2);
    step("ring_resume", 1'b1, 3);
    nreset = 1'b0;
    step("ring_reset", 1'b1, 0);
    nreset = 1'b1;
    step("ring_rel", 1'b1, 0);
    step("ring_rel_1", 1'b1, 1);
`else
    // holding go in DONE starts nothing new
    for (int i = 0; i < 3; i++) step("done_hold", 1'b1, 0);

    // restart: one low cycle returns to IDLE, then a full new sweep
    step("restart_drop", 1'b0, 0);
    step("restart_start", 1'b1, 0);
    for (int i = 1; i <= 7; i++) step("restart_sweep", 1'b1, i);
    step("restart_wrap", 1'b1, 0);

    // pause at 3 for 4 edges, then continue
    step("pause_drop", 1'b0, 0);
    step("pause_start", 1'b1, 0);
    for (int i = 1; i <= 3; i++) step("pause_run", 1'b1, i);
    for (int i = 0; i < 4; i++) step("pause_hold", 1'b0, 3);
    step("pause_resume4", 1'b1, 4);
    step("pause_resume5", 1'b1, 5);

    // reset at count 5 with go high, then extra 0 on release
    nreset = 1'b0;
    step("midrun_reset", 1'b1, 0);
    nreset = 1'b1;
    step("midrun_rel0", 1'b1, 0);
    step("midrun_rel1", 1'b1, 1);
    step("midrun_rel2", 1'b1, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
